// File: rtl/sram_stream_buf_if.sv
// Stream/bus interface for sram_stream_buf: pointer load, write and read
// streams, clear control and status. The master drives requests; the slave
// (the buffer) answers with handshakes, read data and status.
interface sram_stream_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  logic              ld;
  logic [ADDR_W-1:0] addr_in;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_val;
  logic              busy;
  logic [ADDR_W-1:0] ptr;
  logic              wrap;

  modport master (
    output ld, addr_in, wr_valid, wr_data, rd_req, clr_start, clr_val,
    input  wr_ready, rd_ready, rd_valid, rd_data, busy, ptr, wrap
  );

  modport slave (
    input  ld, addr_in, wr_valid, wr_data, rd_req, clr_start, clr_val,
    output wr_ready, rd_ready, rd_valid, rd_data, busy, ptr, wrap
  );
endinterface

// File: rtl/sram_stream_buf.sv
// Single-clock track/sector buffer RAM with an auto-incrementing pointer,
// valid/ready write and read streams, registered read data and a hardware
// clear engine that fills every word with a constant.
module sram_stream_buf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input logic                clk,
  input logic                rst_n,
  sram_stream_buf_if.slave   bus_io
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              wrap_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              wr_ready;
  logic              rd_ready;
  logic              wr_fire;
  logic              rd_fire;
  logic              ptr_at_last;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] ptr_ld;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Handshakes follow the IDLE priority: clear, then load, then write, then read.
  assign idle     = (state_q == ST_IDLE);
  assign wr_ready = idle && !bus_io.clr_start && !bus_io.ld;
  assign rd_ready = wr_ready && !bus_io.wr_valid;
  assign wr_fire  = bus_io.wr_valid && wr_ready;
  assign rd_fire  = bus_io.rd_req && rd_ready;

  // Pointer wraps at DEPTH, not at the power of two; loads are reduced mod DEPTH.
  assign ptr_at_last = (ptr_q == LAST);
  assign ptr_inc     = ptr_at_last ? '0 : ptr_q + ADDR_W'(1);
  assign ptr_ld      = ADDR_W'(32'(bus_io.addr_in) % 32'(DEPTH));

  // The single RAM write port is shared by the write stream and the clear engine.
  assign mem_we    = wr_fire || (state_q == ST_CLEAR);
  assign mem_waddr = (state_q == ST_CLEAR) ? clr_cnt_q : ptr_q;
  assign mem_wdata = (state_q == ST_CLEAR) ? clr_val_q : bus_io.wr_data;

  // Next-state logic for the IDLE/CLEAR controller and the pointer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    clr_val_d = clr_val_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.clr_start) begin
          state_d   = ST_CLEAR;
          clr_val_d = bus_io.clr_val;
          clr_cnt_d = '0;
        end else if (bus_io.ld) begin
          ptr_d = ptr_ld;
        end else if (wr_fire || rd_fire) begin
          ptr_d = ptr_inc;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, pointer and registered read-data state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      clr_cnt_q  <= '0;
      clr_val_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_val_q  <= clr_val_d;
      rd_valid_q <= rd_fire;
      wrap_q     <= (wr_fire || rd_fire) && ptr_at_last;
      if (rd_fire) begin
        rd_data_q <= mem[ptr_q];
      end
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto a RAM macro; contents after reset are undefined.
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus_io.wr_ready = wr_ready;
  assign bus_io.rd_ready = rd_ready;
  assign bus_io.rd_valid = rd_valid_q;
  assign bus_io.rd_data  = rd_data_q;
  assign bus_io.busy     = (state_q == ST_CLEAR);
  assign bus_io.ptr      = ptr_q;
  assign bus_io.wrap     = wrap_q;

endmodule
